mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline; sits directly downstream of the EXE/MEM pipeline register and upstream of the MEM/WB register.
- Holds a word-addressed data memory. Performs loads and stores with a fixed, parameterised multi-cycle access latency.
- Drives a ready signal; the hazard/freeze logic uses its inverse to hold all upstream pipeline registers while an access is in flight.

Parameters:
- DEPTH, 64, number of 32-bit words in data memory (power of two).
- BASE_ADDR, 32'd1024, byte address mapped to word 0.
- WAIT_CYCLES, 4, access latency in cycles; legal range 1..15.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- WB_EN_IN  in  1  writeback enable from EXE/MEM register
- MEM_R_EN_IN  in  1  load request
- MEM_W_EN_IN  in  1  store request
- ALU_Res_IN  in  32  effective byte address, or ALU result for non-memory ops
- VAL_RM_IN  in  32  store data
- Dest_IN  in  4  destination register
- WB_EN  out  1  pass-through of WB_EN_IN, combinational
- MEM_R_EN  out  1  pass-through of MEM_R_EN_IN, combinational
- ALU_Res  out  32  pass-through of ALU_Res_IN, combinational
- Dest  out  4  pass-through of Dest_IN, combinational
- MEM_Res  out  32  load data, registered
- ready  out  1  high when the stage can advance; freeze = ~ready

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, MEM_Res=0.
  - ready=1 once rst deasserts and no request is present.
  - Memory array is not cleared.
- req = MEM_R_EN_IN | MEM_W_EN_IN. If both are high, treat as a load and suppress the store.
- Address decode:
  - off = ALU_Res_IN - BASE_ADDR (32-bit wrap); index = off[log2(DEPTH)+1:2]; off[1:0] is ignored.
  - in_range = (ALU_Res_IN >= BASE_ADDR) && (off < DEPTH*4).
- FSM:
  - IDLE:
    - ready = ~req.
    - On req: counter <= WAIT_CYCLES-1, next state WAIT.
  - WAIT:
    - ready=0.
    - counter != 0: counter <= counter-1.
    - counter == 0, load: MEM_Res <= in_range ? mem[index] : 0.
    - counter == 0, store: mem[index] <= VAL_RM_IN, only if in_range; otherwise the store is dropped.
    - After the access, next state DONE.
  - DONE:
    - ready=1 for exactly one cycle; the pipeline advances on this edge.
    - Next state IDLE unconditionally.
- Latency: request first present at edge N; ready=0 for cycles N..N+WAIT_CYCLES; ready=1 in cycle N+WAIT_CYCLES+1 (DONE).
- Inputs must stay stable during WAIT. The freeze guarantees this; the stage does not re-sample them.
- Back-to-back requests: the new request is seen in the IDLE cycle after DONE, so there is a one-cycle ready=1 gap per access.
- Non-memory ops (req=0): ready stays 1, MEM_Res holds its last value, no memory side effects.
- MEM_Res changes only on load completion.
- Reset mid-access: the pending store is discarded (the memory word is unchanged); FSM returns to IDLE.

Optional Feature:
- Macro: MEM_STAGE_STATS_EN.
- When defined, adds three 32-bit output counters, each reset to 0 and wrapping at 2^32:
  - rd_count: +1 on each load completion.
  - wr_count: +1 on each in-range store completion.
  - stall_count: +1 on each cycle with ready=0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 with req=1 -> ready=1, MEM_Res=0, state IDLE; release with req=0 -> ready stays 1.
- Store then load, WAIT_CYCLES=4:
  - Store 32'hDEADBEEF at address 1032 -> ready=0 for 5 cycles, then 1 for one cycle.
  - Load from 1032 -> MEM_Res=32'hDEADBEEF in the DONE cycle.
- Out of range:
  - Store 32'h12345678 at 1020 and at 1024+DEPTH*4 -> all words unchanged.
  - Load from 1020 -> MEM_Res=0 with normal 5-cycle latency.
- Reset mid-store: drive rst=0 two cycles into the WAIT of a store of 32'hCAFEF00D to 1028 -> word at 1028 keeps its prior value; ready=1 after reset.
- Pass-through: MEM_R_EN=MEM_W_EN=0, ALU_Res_IN=32'h55, Dest_IN=4'd7 -> ready=1 every cycle; ALU_Res=32'h55, Dest=7 in the same cycle; MEM_Res unchanged.
- With MEM_STAGE_STATS_EN: 2 loads, 1 in-range store, 1 out-of-range store, WAIT_CYCLES=4 -> rd_count=2, wr_count=1, stall_count=20.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: EXE/MEM-side request bundle and MEM/WB-side results.
// slave = memory stage, master = surrounding pipeline.
interface mem_stage_if;
    logic        WB_EN_IN;
    logic        MEM_R_EN_IN;
    logic        MEM_W_EN_IN;
    logic [31:0] ALU_Res_IN;
    logic [31:0] VAL_RM_IN;
    logic [3:0]  Dest_IN;
    logic        WB_EN;
    logic        MEM_R_EN;
    logic [31:0] ALU_Res;
    logic [3:0]  Dest;
    logic [31:0] MEM_Res;
    logic        ready;

    modport slave (
        input  WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN,
        input  ALU_Res_IN, VAL_RM_IN, Dest_IN,
        output WB_EN, MEM_R_EN, ALU_Res, Dest,
        output MEM_Res, ready
    );

    modport master (
        output WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN,
        output ALU_Res_IN, VAL_RM_IN, Dest_IN,
        input  WB_EN, MEM_R_EN, ALU_Res, Dest,
        input  MEM_Res, ready
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: multi-cycle word-addressed data memory stage.
// Optional MEM_STAGE_STATS_EN adds rd/wr/stall counters.
module mem_stage #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MEM_STAGE_STATS_EN
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] stall_count,
`endif
    mem_stage_if.slave  bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] LP_SPAN = 32'(DEPTH * 4);
    localparam logic [3:0]  LP_CNT0 = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_mem_res;
    logic [31:0] r_mem [DEPTH];

    logic        w_req;
    logic        w_load;
    logic        w_store;
    logic        w_ready;
    logic        w_done;
    logic        w_in_range;
    logic [31:0] w_off;
    logic [AW-1:0] w_idx;

    assign w_req      = bus.MEM_R_EN_IN | bus.MEM_W_EN_IN;
    assign w_load     = bus.MEM_R_EN_IN;
    assign w_store    = bus.MEM_W_EN_IN & ~bus.MEM_R_EN_IN;
    assign w_off      = bus.ALU_Res_IN - BASE_ADDR;
    assign w_idx      = w_off[AW+1:2];
    assign w_in_range = (bus.ALU_Res_IN >= BASE_ADDR) && (w_off < LP_SPAN);
    assign w_done     = (r_state == S_WAIT) && (r_cnt == 4'd0);

    assign bus.WB_EN    = bus.WB_EN_IN;
    assign bus.MEM_R_EN = bus.MEM_R_EN_IN;
    assign bus.ALU_Res  = bus.ALU_Res_IN;
    assign bus.Dest     = bus.Dest_IN;
    assign bus.MEM_Res  = r_mem_res;
    assign bus.ready    = w_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next state and ready; ready held high while reset is asserted.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_ready = ~(w_req & rst);
                if (w_req) w_next = S_WAIT;
            end
            S_WAIT: begin
                w_ready = 1'b0;
                if (r_cnt == 4'd0) w_next = S_DONE;
            end
            S_DONE: begin
                w_ready = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_ready = 1'b1;
                w_next  = S_IDLE;
            end
        endcase
    end

    // Latency countdown, loaded on request acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 4'd0;
        end else if (r_state == S_IDLE && w_req) begin
            r_cnt <= LP_CNT0;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Load result register; out-of-range loads return zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_res <= 32'd0;
        end else if (w_done && w_load) begin
            r_mem_res <= w_in_range ? r_mem[w_idx] : 32'd0;
        end
    end

    // Memory write; reset forces IDLE so a pending store never lands.
    always_ff @(posedge clk) begin
        if (w_done && w_store && w_in_range) begin
            r_mem[w_idx] <= bus.VAL_RM_IN;
        end
    end

`ifdef MEM_STAGE_STATS_EN
    // Access and stall statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count    <= 32'd0;
            wr_count    <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (w_done && w_load)
                rd_count <= rd_count + 32'd1;
            if (w_done && w_store && w_in_range)
                wr_count <= wr_count + 32'd1;
            if (!w_ready)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage.
// Build with MEM_STAGE_STATS_EN to also cover the counters.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    mem_stage_if bus ();

`ifdef MEM_STAGE_STATS_EN
    logic [31:0] rd_count, wr_count, stall_count;
`endif

    mem_stage #(
        .DEPTH(64), .BASE_ADDR(32'd1024), .WAIT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef MEM_STAGE_STATS_EN
        .rd_count(rd_count),
        .wr_count(wr_count),
        .stall_count(stall_count),
`endif
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.MEM_R_EN_IN = 1'b0;
        bus.MEM_W_EN_IN = 1'b0;
    endtask

    // Issue one access, count ready=0 cycles, leave the stage in DONE.
    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] addr,
                          input logic [31:0] data,
                          input string tag);
        int n;
        bus.MEM_R_EN_IN = rd;
        bus.MEM_W_EN_IN = wr;
        bus.ALU_Res_IN  = addr;
        bus.VAL_RM_IN   = data;
        #1;
        n = 0;
        while (!bus.ready && n < 40) begin
            n++;
            step();
        end
        chk(tag, 32'(n), 32'd5);
    endtask

    // Finish the DONE cycle and return to IDLE.
    task automatic finish_acc();
        idle_in();
        step();
    endtask

    initial begin
        bus.WB_EN_IN    = 1'b0;
        bus.MEM_R_EN_IN = 1'b1;
        bus.MEM_W_EN_IN = 1'b0;
        bus.ALU_Res_IN  = 32'd1024;
        bus.VAL_RM_IN   = 32'd0;
        bus.Dest_IN     = 4'd0;
        rst = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_memres", bus.MEM_Res, 32'd0);
        idle_in();
        #2 rst = 1'b1;
        step();
        chk("rel_ready", 32'(bus.ready), 32'd1);

        access(1'b0, 1'b1, 32'd1024, 32'hA0A0A0A0, "pre0_lat");
        finish_acc();
        access(1'b0, 1'b1, 32'd1276, 32'hB0B0B0B0, "pre63_lat");
        finish_acc();
        access(1'b0, 1'b1, 32'd1028, 32'h11111111, "pre1_lat");
        finish_acc();

        access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, "st_lat");
        chk("st_done_rdy", 32'(bus.ready), 32'd1);
        finish_acc();
        access(1'b1, 1'b0, 32'd1032, 32'd0, "ld_lat");
        chk("ld_data", bus.MEM_Res, 32'hDEADBEEF);
        finish_acc();

        access(1'b1, 1'b1, 32'd1032, 32'h0BAD0BAD, "rw_lat");
        chk("rw_is_load", bus.MEM_Res, 32'hDEADBEEF);
        finish_acc();
        access(1'b1, 1'b0, 32'd1032, 32'd0, "rw_chk_lat");
        chk("rw_no_store", bus.MEM_Res, 32'hDEADBEEF);
        finish_acc();

        access(1'b0, 1'b1, 32'd1020, 32'h12345678, "oor_lo_lat");
        finish_acc();
        access(1'b0, 1'b1, 32'd1280, 32'h12345678, "oor_hi_lat");
        finish_acc();
        access(1'b1, 1'b0, 32'd1024, 32'd0, "w0_lat");
        chk("w0_kept", bus.MEM_Res, 32'hA0A0A0A0);
        finish_acc();
        access(1'b1, 1'b0, 32'd1276, 32'd0, "w63_lat");
        chk("w63_kept", bus.MEM_Res, 32'hB0B0B0B0);
        finish_acc();
        access(1'b1, 1'b0, 32'd1020, 32'd0, "oor_ld_lat");
        chk("oor_ld_zero", bus.MEM_Res, 32'd0);
        finish_acc();
        access(1'b1, 1'b0, 32'd1035, 32'd0, "unal_lat");
        chk("unal_ld", bus.MEM_Res, 32'hDEADBEEF);
        finish_acc();

        bus.WB_EN_IN   = 1'b1;
        bus.ALU_Res_IN = 32'h55;
        bus.Dest_IN    = 4'd7;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("pt_ready", 32'(bus.ready), 32'd1);
            chk("pt_alu", bus.ALU_Res, 32'h55);
            chk("pt_dest", 32'(bus.Dest), 32'd7);
            chk("pt_wben", 32'(bus.WB_EN), 32'd1);
            chk("pt_memres", bus.MEM_Res, 32'hDEADBEEF);
            step();
        end
        bus.WB_EN_IN = 1'b0;

        bus.MEM_W_EN_IN = 1'b1;
        bus.ALU_Res_IN  = 32'd1028;
        bus.VAL_RM_IN   = 32'hCAFEF00D;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(bus.ready), 32'd1);
        chk("mid_rst_res", bus.MEM_Res, 32'd0);
        step();
        idle_in();
        #2 rst = 1'b1;
        step();
        chk("post_rst_rdy", 32'(bus.ready), 32'd1);
        access(1'b1, 1'b0, 32'd1028, 32'd0, "mid_ld_lat");
        chk("mid_kept", bus.MEM_Res, 32'h11111111);
        finish_acc();

`ifdef MEM_STAGE_STATS_EN
        rst = 1'b0;
        step();
        chk("st_rst_rd", rd_count, 32'd0);
        #2 rst = 1'b1;
        step();
        access(1'b1, 1'b0, 32'd1032, 32'd0, "s_ld1");
        finish_acc();
        access(1'b1, 1'b0, 32'd1024, 32'd0, "s_ld2");
        finish_acc();
        access(1'b0, 1'b1, 32'd1040, 32'h77, "s_st_in");
        finish_acc();
        access(1'b0, 1'b1, 32'd1020, 32'h88, "s_st_oor");
        finish_acc();
        step();
        chk("rd_count", rd_count, 32'd2);
        chk("wr_count", wr_count, 32'd1);
        chk("stall_count", stall_count, 32'd20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
